debounce_multi: RTL and testbench

Parametrised multi-channel button debouncer for the TapTempo front end. Each channel synchronises a raw button input and optionally inverts it. It accepts a level change only after the input has been stable for a programmable number of `tp_i` time-pulse ticks; a bounce during the count aborts it. The block outputs the debounced level plus single-cycle press, release and long-press (hold) event strobes. It sits between the pad inputs and the tempo-measurement logic, sharing the common `tp_i` timebase.

---
 rtl/debounce_pkg.sv | 25 ++
 rtl/debounce_chan.sv | 138 +++++++++++++
 rtl/debounce_multi.sv | 43 ++++
 tb/tb_debounce_multi.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared state encodings and sizing helpers
// for the debounce_multi channel logic.
package debounce_pkg;

  localparam logic [1:0] WAIT_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] CNT_HIGH  = 2'd2;
  localparam logic [1:0] CNT_LOW   = 2'd3;

  function automatic int max_count(
    input int deb_ns,
    input int pulse_ns
  );
    return deb_ns / pulse_ns;
  endfunction

  function automatic int cnt_width(input int mc);
    return (mc < 2) ? 1 : $clog2(mc);
  endfunction

  function automatic int hold_width(input int h);
    return (h < 1) ? 1 : $clog2(h + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, level FSM,
// stable-time counter, hold counter and strobes.
import debounce_pkg::*;

module debounce_chan #(
  parameter int   MAX_COUNT  = 4,
  parameter int   HOLD_TICKS = 0,
  parameter logic ACTIVE_LOW = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tp_i,
  input  logic btn_i,
  output logic btn_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int CW = cnt_width(MAX_COUNT);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(MAX_COUNT - 1);

  logic [1:0]    sync_q;
  logic          s;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_d, release_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign s = sync_q[1] ^ ACTIVE_LOW;

  // An abort always wins over a coincident tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      WAIT_LOW: begin
        if (s) begin
          state_d = CNT_HIGH;
          cnt_d   = '0;
        end
      end
      CNT_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end else if (tp_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = WAIT_HIGH;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = CNT_LOW;
          cnt_d   = '0;
        end
      end
      CNT_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end else if (tp_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = WAIT_LOW;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= WAIT_LOW;
      cnt_q     <= '0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_o   <= press_d;
      release_o <= release_d;
    end
  end

  assign btn_o = (state_q == WAIT_HIGH) ||
                 (state_q == CNT_LOW);

  if (HOLD_TICKS > 0) begin : g_hold
    localparam int HW = hold_width(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_MAX =
      HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_PRE =
      HW'(HOLD_TICKS - 1);

    logic [HW-1:0] hold_q;
    logic          hold_s;

    // Saturates, so the strobe fires once per press.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        hold_q <= '0;
        hold_s <= 1'b0;
      end else begin
        hold_s <= 1'b0;
        if (state_q != WAIT_HIGH) begin
          hold_q <= '0;
        end else if (tp_i && hold_q != HOLD_MAX) begin
          hold_q <= hold_q + HW'(1);
          hold_s <= (hold_q == HOLD_PRE);
        end
      end
    end

    assign hold_o = hold_s;
  end else begin : g_no_hold
    assign hold_o = 1'b0;
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel button debouncer sharing one
// tp_i timebase across all channels.
import debounce_pkg::*;

module debounce_multi #(
  parameter int CHANNELS        = 4,
  parameter int PULSE_PER_NS    = 4096,
  parameter int DEBOUNCE_PER_NS = 16_777_216,
  parameter int HOLD_TICKS      = 0,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW =
    {CHANNELS{1'b0}}
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tp_i,
  input  logic [CHANNELS-1:0] btn_i,
  output logic [CHANNELS-1:0] btn_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] hold_o
);

  localparam int MAX_COUNT =
    max_count(DEBOUNCE_PER_NS, PULSE_PER_NS);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    debounce_chan #(
      .MAX_COUNT  (MAX_COUNT),
      .HOLD_TICKS (HOLD_TICKS),
      .ACTIVE_LOW (ACTIVE_LOW[n])
    ) u_chan (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .tp_i      (tp_i),
      .btn_i     (btn_i[n]),
      .btn_o     (btn_o[n]),
      .press_o   (press_o[n]),
      .release_o (release_o[n]),
      .hold_o    (hold_o[n])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed plus randomized bench for debounce_multi
// against a level/stable-time reference model.
module tb_debounce_multi;

  localparam int CH = 2;
  localparam int MC = 4;
  localparam int HT = 3;
  localparam logic [1:0] AL = 2'b10;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       tp_i;
  logic [1:0] btn_i;
  logic [1:0] btn_o, press_o, release_o, hold_o;

  always #5 clk_i = ~clk_i;

  debounce_multi #(
    .CHANNELS        (CH),
    .PULSE_PER_NS    (1),
    .DEBOUNCE_PER_NS (MC),
    .HOLD_TICKS      (HT),
    .ACTIVE_LOW      (AL)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tp_i      (tp_i),
    .btn_i     (btn_i),
    .btn_o     (btn_o),
    .press_o   (press_o),
    .release_o (release_o),
    .hold_o    (hold_o)
  );

  bit         m_lvl  [CH];
  bit         m_busy [CH];
  int         m_cnt  [CH];
  int         m_hc   [CH];
  bit         m_s1   [CH];
  bit         m_s2   [CH];
  logic [1:0] e_btn, e_press, e_rel, e_hold;
  logic [1:0] al_v;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag,
                     input logic [1:0] got,
                     input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b want=%b t=%0t",
             tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m_lvl[c]  = 1'b0;
      m_busy[c] = 1'b0;
      m_cnt[c]  = 0;
      m_hc[c]   = 0;
      m_s1[c]   = 1'b0;
      m_s2[c]   = 1'b0;
    end
    e_btn   = '0;
    e_press = '0;
    e_rel   = '0;
    e_hold  = '0;
  endtask

  // Debounced level accepted after MC ticks of a
  // differing input; hold counts ticks while stably high.
  task automatic model_step();
    bit s, stable;
    e_press = '0;
    e_rel   = '0;
    e_hold  = '0;
    for (int c = 0; c < CH; c++) begin
      s      = m_s2[c] ^ al_v[c];
      stable = m_lvl[c] && !m_busy[c];
      if (!stable) m_hc[c] = 0;
      else if (tp_i && m_hc[c] < HT) begin
        m_hc[c]++;
        if (m_hc[c] == HT) e_hold[c] = 1'b1;
      end
      if (!m_busy[c]) begin
        if (s != m_lvl[c]) begin
          m_busy[c] = 1'b1;
          m_cnt[c]  = 0;
        end
      end else if (s == m_lvl[c]) begin
        m_busy[c] = 1'b0;
        m_cnt[c]  = 0;
      end else if (tp_i) begin
        if (m_cnt[c] == MC - 1) begin
          m_lvl[c]  = s;
          m_busy[c] = 1'b0;
          m_cnt[c]  = 0;
          if (s) e_press[c] = 1'b1;
          else   e_rel[c]   = 1'b1;
        end else begin
          m_cnt[c]++;
        end
      end
      e_btn[c] = m_lvl[c];
      m_s2[c]  = m_s1[c];
      m_s1[c]  = btn_i[c];
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    if (rst_i) model_clear();
    else       model_step();
    #1;
    chk("btn",     btn_o,     e_btn);
    chk("press",   press_o,   e_press);
    chk("release", release_o, e_rel);
    chk("hold",    hold_o,    e_hold);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    model_clear();
    chk("rst_btn",     btn_o,     2'b00);
    chk("rst_press",   press_o,   2'b00);
    chk("rst_release", release_o, 2'b00);
    chk("rst_hold",    hold_o,    2'b00);
    cycles(2);
    rst_i = 1'b0;
  endtask

  initial begin
    al_v  = AL;
    rst_i = 1'b1;
    tp_i  = 1'b1;
    btn_i = 2'b10;
    model_clear();
    #12;
    do_reset();
    cycles(3);

    // clean press, then hold, then release
    btn_i[0] = 1'b1;
    cycles(6);
    chk("clean_early", press_o, 2'b00);
    cyc();
    chk("clean_press", press_o, 2'b01);
    chk("clean_btn",   btn_o,   2'b01);
    cycles(3);
    chk("hold_pulse", hold_o, 2'b01);
    cycles(2);
    btn_i[0] = 1'b0;
    cycles(6);
    chk("rel_early", release_o, 2'b00);
    cyc();
    chk("rel_pulse", release_o, 2'b01);
    chk("rel_btn",   btn_o,     2'b00);
    cycles(3);

    // bounce during the high count
    btn_i[0] = 1'b1;
    cycles(4);
    btn_i[0] = 1'b0;
    cyc();
    btn_i[0] = 1'b1;
    cycles(6);
    chk("bounce_early", press_o, 2'b00);
    chk("bounce_btn",   btn_o,   2'b00);
    cyc();
    chk("bounce_press", press_o, 2'b01);
    btn_i[0] = 1'b0;
    cycles(10);

    // active-low channel 1
    btn_i[1] = 1'b0;
    cycles(6);
    chk("al_early", press_o, 2'b00);
    cyc();
    chk("al_press", press_o, 2'b10);
    chk("al_btn",   btn_o,   2'b10);
    btn_i[1] = 1'b1;
    cycles(10);

    // reset in CNT_HIGH, re-debounce, reset in WAIT_HIGH
    btn_i[0] = 1'b1;
    cycles(4);
    do_reset();
    cycles(6);
    chk("rd_early", press_o, 2'b00);
    cyc();
    chk("rd_press", press_o, 2'b01);
    cycles(2);
    do_reset();
    btn_i[0] = 1'b0;
    cycles(6);

    // tp_i gap mid-count
    btn_i[0] = 1'b1;
    cycles(4);
    tp_i = 1'b0;
    cycles(20);
    chk("gap_btn",   btn_o,   2'b00);
    chk("gap_press", press_o, 2'b00);
    tp_i = 1'b1;
    cycles(2);
    chk("gap_early", press_o, 2'b00);
    cyc();
    chk("gap_press2", press_o, 2'b01);
    btn_i[0] = 1'b0;
    cycles(10);

    // randomized bouncing, sparse ticks, rare resets
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 9) == 0)
          btn_i[c] = ~btn_i[c];
      tp_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
